i2c_rd_frame_packer: RTL and testbench
======================================

Name: i2c_rd_frame_packer

Overview:
- Downstream stage of the I2C master wrapper. Consumes its read-byte stream (cfg_rdata_out / cfg_rvalid_out).
- Snoops the internal config bus to learn the expected read length and when a transaction starts.
- Buffers the read bytes, then emits one response frame (header, type, status, length, payload, XOR checksum) on a byte-stream valid/ready port toward the USB-CDC TX path.
- Handles short or aborted reads, such as an address NACK, with an idle timeout.

Parameters:
- MAX_LEN, 32: payload buffer depth in bytes (1..255).
- TIMEOUT_CYCLES, 50000: clk cycles with no new read byte before a COLLECT is closed as short.
- FRAME_HDR, 8'hA5: first byte of every frame.
- FRAME_TYPE, 8'h02: type byte for an I2C read response.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset (see Behaviour)
- cfg_addr  in  16  config bus address (snooped)
- cfg_wdata  in  32  config bus write data (snooped)
- cfg_write  in  1  config bus write strobe (snooped)
- i2c_rdata  in  8  read byte from the I2C master
- i2c_rvalid  in  1  one-cycle strobe qualifying i2c_rdata
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts the byte when tx_valid && tx_ready
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky; set when an arm arrives while busy; cleared only by reset

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset: all outputs 0, state IDLE, counters 0, rlen_shadow 0.
- Snoop LEN:
  - A cfg_write to `I2C_BASE_ADDR+`I2C_REG_OFFSET_LEN loads rlen_shadow <= cfg_wdata[7:0].
  - This happens in any state. It affects only the next arm.
- Snoop CTRL:
  - A cfg_write to `I2C_BASE_ADDR+`I2C_REG_OFFSET_CTRL with cfg_wdata[0]=1 is an arm.
  - If the same cycle also writes LEN, the new rlen_shadow value is used.
- Arm in IDLE:
  - If rlen_shadow==0, there is no frame and the block stays IDLE.
  - Otherwise: expected <= rlen_shadow, cnt <= 0, tmo <= 0, status <= 0, go to COLLECT.
- Arm while not IDLE: ignored, and overrun <= 1.
- i2c_rvalid in any state other than COLLECT: byte dropped, no flag.
- COLLECT, on each cycle with i2c_rvalid:
  - If cnt < MAX_LEN: buf[cnt] <= i2c_rdata, cnt++.
  - Otherwise: byte discarded and status[1] <= 1 (overflow).
  - In both cases recv++ and tmo <= 0.
  - On cycles without i2c_rvalid: tmo++.
- Leaving COLLECT:
  - Next cycle goes to HDR when recv == expected (counted including the byte of that cycle).
  - Also goes to HDR when tmo reaches TIMEOUT_CYCLES-1 without a byte; in that case status[0] <= 1 (short).
- Frame states: HDR -> TYPE -> STAT -> LEN -> PAY -> CSUM -> IDLE.
  - Each state holds its byte on tx_data with tx_valid=1 until tx_ready is seen, then advances on the next clk.
  - Bytes in order: FRAME_HDR, FRAME_TYPE, status, len = cnt (stored bytes), buf[0..cnt-1], then csum.
- PAY: a rd_ptr walks 0..cnt-1. If cnt==0 (short with no bytes), LEN goes directly to CSUM.
- Checksum: csum = XOR of TYPE, STAT, LEN and all payload bytes. Accumulated as each byte is accepted; HDR is excluded.
- Output register timing:
  - tx_valid and tx_data are registered outputs.
  - tx_valid drops in the cycle after the CSUM handshake.
  - Throughput is 1 byte per clk while tx_ready is held high.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- Buffer: a single register array, MAX_LEN x 8. Indices are clog2(MAX_LEN) bits. cnt and recv are 8 bits; recv saturates at 255.
- Reset mid-frame: frame abandoned, tx_valid=0 immediately. No partial-frame recovery.

Test Plan:
- Normal read: LEN=0x0003, arm, bytes 11,22,33 with gaps, tx_ready=1 -> frame A5 02 00 03 11 22 33 csum=0x02^0x00^0x03^0x11^0x22^0x33=0x01, then busy=0.
- Address NACK: LEN rlen=4, arm, no rvalid -> after TIMEOUT_CYCLES the frame is A5 02 01 00 03 (csum 0x02^0x01^0x00).
- Overflow (MAX_LEN=4): rlen=6, bytes 01..06 -> A5 02 02 04 01 02 03 04 csum=0x02^0x02^0x04^0x04=0x00.
- Backpressure: tx_ready toggled randomly in the first test -> identical byte sequence; tx_data is stable whenever valid && !ready.
- Arm while busy: second CTRL arm during PAY -> overrun=1, current frame unchanged, no second frame. A later arm from IDLE (rlen=0, write-only transaction) produces no frame and busy stays 0.
- Async reset asserted mid-PAY -> tx_valid=0, busy=0, overrun=0 that cycle; a subsequent normal read frames correctly.

Source files
------------

// File: rtl/i2c_rd_frame_packer.sv
// Collects the I2C master's read bytes for one armed transaction and emits a
// response frame: HDR, TYPE, STATUS, LEN, payload, XOR checksum.
`ifndef I2C_BASE_ADDR
`define I2C_BASE_ADDR (16'h0100)
`endif
`ifndef I2C_REG_OFFSET_CTRL
`define I2C_REG_OFFSET_CTRL (16'h0000)
`endif
`ifndef I2C_REG_OFFSET_LEN
`define I2C_REG_OFFSET_LEN (16'h0008)
`endif

module i2c_rd_frame_packer #(
   parameter int         MAX_LEN        = 32,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter logic [7:0] FRAME_HDR      = 8'hA5,
   parameter logic [7:0] FRAME_TYPE     = 8'h02
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cfg_addr,
   input  logic [31:0] cfg_wdata,
   input  logic        cfg_write,
   input  logic [7:0]  i2c_rdata,
   input  logic        i2c_rvalid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        overrun
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [15:0] LEN_ADDR = `I2C_BASE_ADDR + `I2C_REG_OFFSET_LEN;
   localparam logic [15:0] CTRL_ADDR = `I2C_BASE_ADDR + `I2C_REG_OFFSET_CTRL;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_HDR,
      ST_TYPE,
      ST_STAT,
      ST_LEN,
      ST_PAY,
      ST_CSUM
   } state_t;

   state_t           r_state;
   logic [7:0]       r_rlenShadow;
   logic [7:0]       r_expected;
   logic [7:0]       r_cnt;
   logic [7:0]       r_recv;
   logic [TMO_W-1:0] r_tmo;
   logic [1:0]       r_status;
   logic [IDX_W-1:0] r_rdPtr;
   logic [7:0]       r_csum;
   logic [7:0]       r_txData;
   logic             r_txValid;
   logic             r_overrun;
   logic [7:0]       r_buf [MAX_LEN];

   logic             w_lenWr;
   logic             w_arm;
   logic [7:0]       w_rlenEff;
   logic [7:0]       w_recvNext;
   logic             w_hs;
   logic [IDX_W-1:0] w_rdNext;
   logic             w_lastPay;
   logic [7:0]       w_csumNext;
   logic             w_unusedBits;

   assign w_lenWr      = cfg_write && (cfg_addr == LEN_ADDR);
   assign w_arm        = cfg_write && (cfg_addr == CTRL_ADDR) && cfg_wdata[0];
   assign w_rlenEff    = w_lenWr ? cfg_wdata[7:0] : r_rlenShadow;
   assign w_recvNext   = (r_recv == 8'hFF) ? 8'hFF : r_recv + 8'd1;
   assign w_hs         = r_txValid && tx_ready;
   assign w_rdNext     = r_rdPtr + IDX_W'(1);
   assign w_lastPay    = (8'(r_rdPtr) == r_cnt - 8'd1);
   assign w_csumNext   = r_csum ^ r_txData;
   assign w_unusedBits = ^cfg_wdata[31:8];

   assign tx_data  = r_txData;
   assign tx_valid = r_txValid;
   assign busy     = (r_state != ST_IDLE);
   assign overrun  = r_overrun;

   // Payload storage has no reset; it is only read back below the stored count.
   always_ff @(posedge clk) begin
      if (r_state == ST_COLLECT && i2c_rvalid && r_cnt < MAX_LEN_B) begin
         r_buf[r_cnt[IDX_W-1:0]] <= i2c_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_rlenShadow <= 8'd0;
         r_expected   <= 8'd0;
         r_cnt        <= 8'd0;
         r_recv       <= 8'd0;
         r_tmo        <= '0;
         r_status     <= 2'd0;
         r_rdPtr      <= '0;
         r_csum       <= 8'd0;
         r_txData     <= 8'd0;
         r_txValid    <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_lenWr) begin
            r_rlenShadow <= cfg_wdata[7:0];
         end
         if (w_arm && r_state != ST_IDLE) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_arm && w_rlenEff != 8'd0) begin
                  r_expected <= w_rlenEff;
                  r_cnt      <= 8'd0;
                  r_recv     <= 8'd0;
                  r_tmo      <= '0;
                  r_status   <= 2'd0;
                  r_csum     <= 8'd0;
                  r_state    <= ST_COLLECT;
               end
            end
            // Bytes beyond the buffer still count toward the expected length.
            ST_COLLECT: begin
               if (i2c_rvalid) begin
                  if (r_cnt < MAX_LEN_B) begin
                     r_cnt <= r_cnt + 8'd1;
                  end else begin
                     r_status[1] <= 1'b1;
                  end
                  r_recv <= w_recvNext;
                  r_tmo  <= '0;
                  if (w_recvNext == r_expected) begin
                     r_state   <= ST_HDR;
                     r_txData  <= FRAME_HDR;
                     r_txValid <= 1'b1;
                  end
               end else if (r_tmo == TMO_LAST) begin
                  r_status[0] <= 1'b1;
                  r_state     <= ST_HDR;
                  r_txData    <= FRAME_HDR;
                  r_txValid   <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            ST_HDR: begin
               if (w_hs) begin
                  r_state  <= ST_TYPE;
                  r_txData <= FRAME_TYPE;
               end
            end
            ST_TYPE: begin
               if (w_hs) begin
                  r_csum   <= w_csumNext;
                  r_state  <= ST_STAT;
                  r_txData <= {6'd0, r_status};
               end
            end
            ST_STAT: begin
               if (w_hs) begin
                  r_csum   <= w_csumNext;
                  r_state  <= ST_LEN;
                  r_txData <= r_cnt;
               end
            end
            ST_LEN: begin
               if (w_hs) begin
                  r_csum  <= w_csumNext;
                  r_rdPtr <= '0;
                  if (r_cnt == 8'd0) begin
                     r_state  <= ST_CSUM;
                     r_txData <= w_csumNext;
                  end else begin
                     r_state  <= ST_PAY;
                     r_txData <= r_buf[0];
                  end
               end
            end
            // The checksum byte is the running XOR including the last payload byte.
            ST_PAY: begin
               if (w_hs) begin
                  r_csum <= w_csumNext;
                  if (w_lastPay) begin
                     r_state  <= ST_CSUM;
                     r_txData <= w_csumNext;
                  end else begin
                     r_rdPtr  <= w_rdNext;
                     r_txData <= r_buf[w_rdNext];
                  end
               end
            end
            ST_CSUM: begin
               if (w_hs) begin
                  r_txValid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_txValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_rd_frame_packer.sv
// Bench for i2c_rd_frame_packer: a table of read transactions with expected
// frames, plus hand sequences for overrun, idle arm with zero length and mid-frame reset.
`ifndef I2C_BASE_ADDR
`define I2C_BASE_ADDR (16'h0100)
`endif
`ifndef I2C_REG_OFFSET_CTRL
`define I2C_REG_OFFSET_CTRL (16'h0000)
`endif
`ifndef I2C_REG_OFFSET_LEN
`define I2C_REG_OFFSET_LEN (16'h0008)
`endif

module tb_i2c_rd_frame_packer;

   localparam logic [15:0] LEN_ADDR  = `I2C_BASE_ADDR + `I2C_REG_OFFSET_LEN;
   localparam logic [15:0] CTRL_ADDR = `I2C_BASE_ADDR + `I2C_REG_OFFSET_CTRL;
   localparam int NUM_VECS = 6;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic [15:0] cfg_addr   = 16'd0;
   logic [31:0] cfg_wdata  = 32'd0;
   logic        cfg_write  = 1'b0;
   logic [7:0]  i2c_rdata  = 8'd0;
   logic        i2c_rvalid = 1'b0;
   logic        tx_ready   = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        overrun;

   int          readyMode = 0;
   int          vecCount  = 0;
   int          missCount = 0;
   logic [7:0]  frameQ [$];
   logic        prevStall = 1'b0;
   logic [7:0]  prevData  = 8'd0;

   typedef struct packed {
      logic [7:0]            rlen;
      logic [3:0]            nBytes;
      logic [1:0]            readyMode;
      logic [3:0]            expLen;
      logic [0:7][7:0]       data;
      logic [0:11][7:0]      exp;
   } vec_t;

   vec_t vecs [NUM_VECS];

   i2c_rd_frame_packer #(
      .MAX_LEN(4),
      .TIMEOUT_CYCLES(16),
      .FRAME_HDR(8'hA5),
      .FRAME_TYPE(8'h02)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata),
      .cfg_write(cfg_write),
      .i2c_rdata(i2c_rdata),
      .i2c_rvalid(i2c_rvalid),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Downstream ready: always on, random, or held off depending on readyMode.
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
   end

   // Captures accepted frame bytes and checks that a stalled byte is held.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            vecCount++;
            if (!tx_valid || tx_data !== prevData) begin
               missCount++;
               $display("[TB] FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                        tx_valid, tx_data, prevData);
            end
         end
         if (tx_valid && tx_ready) frameQ.push_back(tx_data);
         prevStall = tx_valid && !tx_ready;
         prevData  = tx_data;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic cfgWrite(input logic [15:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      cfg_addr  = addr;
      cfg_wdata = data;
      cfg_write = 1'b1;
      @(posedge clk); #1;
      cfg_write = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] d);
      @(posedge clk); #1;
      i2c_rdata  = d;
      i2c_rvalid = 1'b1;
      @(posedge clk); #1;
      i2c_rvalid = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_idle"}, {7'd0, busy}, 8'd0);
   endtask

   task automatic waitPayload(input string name, input logic [7:0] first);
      int n;
      n = 0;
      @(negedge clk);
      while (!(tx_valid && tx_data == first) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_pay_seen"}, {7'd0, tx_valid}, 8'd1);
   endtask

   task automatic applyStimulus(input int idx);
      readyMode = int'(vecs[idx].readyMode);
      frameQ.delete();
      cfgWrite(LEN_ADDR, {24'd0, vecs[idx].rlen});
      cfgWrite(CTRL_ADDR, 32'd1);
      for (int b = 0; b < int'(vecs[idx].nBytes); b++) sendByte(vecs[idx].data[b]);
   endtask

   task automatic checkFrame(input int idx);
      logic [7:0] act;
      waitIdle($sformatf("v%0d", idx));
      repeat (5) @(negedge clk);
      checkOutput($sformatf("v%0d_len", idx), 8'(frameQ.size()), 8'(vecs[idx].expLen));
      for (int i = 0; i < int'(vecs[idx].expLen); i++) begin
         act = (i < frameQ.size()) ? frameQ[i] : 8'hxx;
         checkOutput($sformatf("v%0d_b%0d", idx, i), act, vecs[idx].exp[i]);
      end
   endtask

   logic [7:0] expOv [9] = '{8'hA5, 8'h02, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h46};

   initial begin
      logic sawBusy;
      logic [7:0] act;

      vecs[0] = '{rlen: 8'd3, nBytes: 4'd3, readyMode: 2'd0, expLen: 4'd8,
                  data: '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  exp:  '{8'hA5, 8'h02, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01,
                          8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[1] = vecs[0];
      vecs[1].readyMode = 2'd1;
      vecs[2] = '{rlen: 8'd4, nBytes: 4'd0, readyMode: 2'd0, expLen: 4'd5,
                  data: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  exp:  '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[3] = '{rlen: 8'd6, nBytes: 4'd6, readyMode: 2'd1, expLen: 4'd9,
                  data: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00},
                  exp:  '{8'hA5, 8'h02, 8'h02, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
                          8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[4] = '{rlen: 8'd4, nBytes: 4'd2, readyMode: 2'd0, expLen: 4'd7,
                  data: '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  exp:  '{8'hA5, 8'h02, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h10, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[5] = '{rlen: 8'd0, nBytes: 4'd2, readyMode: 2'd0, expLen: 4'd0,
                  data: '{8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  exp:  '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00}};

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
      checkOutput("rst_tx_data", tx_data, 8'd0);
      checkOutput("rst_busy", {7'd0, busy}, 8'd0);
      checkOutput("rst_overrun", {7'd0, overrun}, 8'd0);
      rst_n = 1'b1;

      for (int v = 0; v < NUM_VECS; v++) begin
         applyStimulus(v);
         checkFrame(v);
      end
      checkOutput("no_overrun_yet", {7'd0, overrun}, 8'd0);

      // Second arm during payload: flagged, frame unaffected, no extra frame
      readyMode = 0;
      frameQ.delete();
      cfgWrite(LEN_ADDR, 32'd4);
      cfgWrite(CTRL_ADDR, 32'd1);
      sendByte(8'h10);
      sendByte(8'h20);
      sendByte(8'h30);
      sendByte(8'h40);
      waitPayload("ovr", 8'h10);
      cfgWrite(CTRL_ADDR, 32'd1);
      checkOutput("ovr_flag", {7'd0, overrun}, 8'd1);
      waitIdle("ovr");
      repeat (30) @(negedge clk);
      checkOutput("ovr_busy_after", {7'd0, busy}, 8'd0);
      checkOutput("ovr_len", 8'(frameQ.size()), 8'd9);
      for (int i = 0; i < 9; i++) begin
         act = (i < frameQ.size()) ? frameQ[i] : 8'hxx;
         checkOutput($sformatf("ovr_b%0d", i), act, expOv[i]);
      end
      checkOutput("ovr_sticky", {7'd0, overrun}, 8'd1);

      // Arm from idle with a zero read length
      frameQ.delete();
      cfgWrite(LEN_ADDR, 32'd0);
      cfgWrite(CTRL_ADDR, 32'd1);
      sawBusy = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy) sawBusy = 1'b1;
      end
      checkOutput("zero_arm_busy", {7'd0, sawBusy}, 8'd0);
      checkOutput("zero_arm_frame", 8'(frameQ.size()), 8'd0);

      // Asynchronous reset in the middle of the payload
      readyMode = 0;
      frameQ.delete();
      cfgWrite(LEN_ADDR, 32'd3);
      cfgWrite(CTRL_ADDR, 32'd1);
      sendByte(8'h11);
      sendByte(8'h22);
      sendByte(8'h33);
      waitPayload("mid_rst", 8'h11);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_tx_valid", {7'd0, tx_valid}, 8'd0);
      checkOutput("mid_rst_busy", {7'd0, busy}, 8'd0);
      checkOutput("mid_rst_overrun", {7'd0, overrun}, 8'd0);
      checkOutput("mid_rst_tx_data", tx_data, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      frameQ.delete();
      applyStimulus(0);
      checkFrame(0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
